// File: rtl/seven_seg_pkg.sv
// Shared segment definitions for the multiplexed hex display.
package seven_seg_pkg;

  // Segment bit positions within a 7-bit GFEDCBA word.
  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;
  localparam int unsigned SEG_W = SEG_G - SEG_A + 1;

  // All segments dark, active-high encoding.
  localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

  // Active-high glyphs indexed by nibble value: 0..9, A, b, C, d, E, F.
  localparam logic [15:0][SEG_W-1:0] GLYPH_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h67, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble-to-glyph decoder with a blanking input.
module hex_to_7seg
  import seven_seg_pkg::*;
(
  input  logic [3:0]       i_nibble,
  input  logic             i_blank,
  output logic [SEG_W-1:0] o_seg
);

  // Blank wins over the glyph lookup.
  always_comb begin
    o_seg = SEG_OFF;
    if (!i_blank) begin
      o_seg = GLYPH_TABLE[i_nibble];
    end
  end

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed hex display scanner with ghost blanking, frame-synchronous
// value update and optional leading-zero suppression.
module seven_segment_scan
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SCAN_DIV       = 25000,
  parameter int unsigned GHOST_CYC      = 250,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b0,
  parameter bit          LZ_BLANK       = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic                    i_load,
  output logic [SEG_W-1:0]        o_seg,
  output logic [NUM_DIGITS-1:0]   o_dig_en,
  output logic                    o_frame
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GHOST = CNT_W'(GHOST_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Output levels meaning "nothing lit" after polarity adjustment.
  localparam logic [SEG_W-1:0]      SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [NUM_DIGITS-1:0] DIG_IDLE = DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                              : {NUM_DIGITS{1'b0}};

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [SEG_W-1:0]        seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic                    frame_q, frame_d;

  logic                    frame_wrap;
  logic [3:0]              cur_nibble;
  logic                    cur_blank;
  logic [SEG_W-1:0]        cur_glyph;

  assign frame_wrap = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

  // Slot counter, digit index and the two-stage value pipeline.
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    idx_d  = idx_q;
    pend_d = pend_q;
    disp_d = disp_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    // Display takes the pending value from before this edge, so a load on the
    // boundary cycle lands one frame later.
    if (frame_wrap) begin
      disp_d = pend_q;
    end
    if (i_load) begin
      pend_d = i_value;
    end
  end

  // Select the active digit and decide leading-zero blanking.
  always_comb begin
    cur_nibble = disp_q[{idx_q, 2'b00} +: 4];
    cur_blank  = LZ_BLANK && (idx_q != '0) && ((disp_q >> {idx_q, 2'b00}) == '0);
  end

  hex_to_7seg u_hex_to_7seg (
    .i_nibble (cur_nibble),
    .i_blank  (cur_blank),
    .o_seg    (cur_glyph)
  );

  // Registered outputs: ghost interval dark, otherwise the indexed digit.
  always_comb begin
    seg_d   = SEG_IDLE;
    dig_d   = DIG_IDLE;
    frame_d = (cnt_q == '0) && (idx_q == '0);
    if (cnt_q >= CNT_GHOST) begin
      seg_d = cur_glyph ^ {SEG_W{SEG_ACTIVE_LOW}};
      dig_d = (NUM_DIGITS'(1) << idx_q) ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      pend_q  <= '0;
      disp_q  <= '0;
      seg_q   <= SEG_IDLE;
      dig_q   <= DIG_IDLE;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      disp_q  <= disp_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      frame_q <= frame_d;
    end
  end

  assign o_seg    = seg_q;
  assign o_dig_en = dig_q;
  assign o_frame  = frame_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Directed bench: 4 digits, 4-cycle slots, 1 ghost cycle, active-low segments.
module tb_seven_segment_scan;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic [6:0]  seg, seg2;
  logic [3:0]  dig, dig2;
  logic        frame, frame2;

  int checks;
  int failures;

  seven_segment_scan #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .GHOST_CYC(1),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b0), .LZ_BLANK(1'b1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_value(value), .i_load(load),
    .o_seg(seg), .o_dig_en(dig), .o_frame(frame)
  );

  seven_segment_scan #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .GHOST_CYC(1),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b0), .LZ_BLANK(1'b0)
  ) dut_nolz (
    .i_clk(clk), .i_rst_n(rst_n), .i_value(value), .i_load(load),
    .o_seg(seg2), .o_dig_en(dig2), .o_frame(frame2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     value;
    logic [3:0][6:0] seg_lz;  // expected o_seg per digit, blanking on
    logic [3:0][6:0] seg_nz;  // expected o_seg per digit, blanking off
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame(input string tag);
    bit found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      step();
      if (frame) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL %s_wait_frame: got no o_frame expected pulse within 40 cycles", tag);
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  // Compare outputs for slot positions s0..15 of a frame; current sample is s0.
  task automatic check_frame(input string tag, input logic [3:0][6:0] e_lz,
                             input logic [3:0][6:0] e_nz, input int s0);
    for (int s = s0; s < 16; s++) begin
      logic [3:0] edig;
      logic [6:0] elz, enz;
      int d;
      if (s != s0) step();
      d = s / 4;
      if (s % 4 == 0) begin
        edig = 4'b0000;
        elz  = 7'h7F;
        enz  = 7'h7F;
      end else begin
        edig = 4'b0001 << d;
        elz  = e_lz[d];
        enz  = e_nz[d];
      end
      chk($sformatf("%s_s%0d_dig", tag, s), {12'h0, dig}, {12'h0, edig});
      chk($sformatf("%s_s%0d_seg", tag, s), {9'h0, seg}, {9'h0, elz});
      chk($sformatf("%s_s%0d_frame", tag, s), {15'h0, frame}, {15'h0, s == 0});
      chk($sformatf("%s_s%0d_dig_nolz", tag, s), {12'h0, dig2}, {12'h0, edig});
      chk($sformatf("%s_s%0d_seg_nolz", tag, s), {9'h0, seg2}, {9'h0, enz});
      chk($sformatf("%s_s%0d_frame_nolz", tag, s), {15'h0, frame2}, {15'h0, s == 0});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_seg"}, {9'h0, seg}, 16'h007F);
    chk({tag, "_dig"}, {12'h0, dig}, 16'h0000);
    chk({tag, "_frame"}, {15'h0, frame}, 16'h0000);
    chk({tag, "_seg_nolz"}, {9'h0, seg2}, 16'h007F);
  endtask

  localparam logic [3:0][6:0] ZERO_LZ  = {7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [3:0][6:0] ZERO_NZ  = {7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [3:0][6:0] ABCD_SEG = {7'h08, 7'h03, 7'h46, 7'h21};
  localparam logic [3:0][6:0] ONES_SEG = {7'h79, 7'h79, 7'h79, 7'h79};
  localparam logic [3:0][6:0] TWOS_SEG = {7'h24, 7'h24, 7'h24, 7'h24};

  initial begin
    checks   = 0;
    failures = 0;
    value    = 16'h0;
    load     = 1'b0;
    rst_n    = 1'b1;

    vecs[0] = '{16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[1] = '{16'h0050, {7'h7F, 7'h7F, 7'h12, 7'h40}, {7'h40, 7'h40, 7'h12, 7'h40}};
    vecs[2] = '{16'hABCD, ABCD_SEG, ABCD_SEG};
    vecs[3] = '{16'h0000, ZERO_LZ, ZERO_NZ};
    vecs[4] = '{16'h8009, {7'h00, 7'h40, 7'h40, 7'h18}, {7'h00, 7'h40, 7'h40, 7'h18}};
    vecs[5] = '{16'h0F00, {7'h7F, 7'h0E, 7'h40, 7'h40}, {7'h40, 7'h0E, 7'h40, 7'h40}};

    // Power-on reset, checked without any clock edge.
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    step();
    step();
    check_reset_outputs("por_held");
    rst_n = 1'b1;
    step();
    check_frame("por_first", ZERO_LZ, ZERO_NZ, 0);

    // Table: load at slot 0, expect the value from the following frame.
    for (int i = 0; i < 6; i++) begin
      wait_frame($sformatf("v%0d_sync", i));
      pulse_load(vecs[i].value);
      wait_frame($sformatf("v%0d_show", i));
      check_frame($sformatf("v%0d", i), vecs[i].seg_lz, vecs[i].seg_nz, 0);
    end

    // Mid-frame load: rest of the current frame keeps 0x0F00.
    wait_frame("mid_sync");
    step();
    step();
    step();
    pulse_load(16'hABCD);
    check_frame("mid_old", vecs[5].seg_lz, vecs[5].seg_nz, 4);
    step();
    check_frame("mid_new", ABCD_SEG, ABCD_SEG, 0);

    // Two loads in one frame, the second on the boundary cycle.
    wait_frame("bnd_sync");
    step();
    step();
    pulse_load(16'h1111);
    for (int n = 0; n < 11; n++) step();
    pulse_load(16'h2222);
    step();
    check_frame("bnd_first", ONES_SEG, ONES_SEG, 0);
    step();
    check_frame("bnd_second", TWOS_SEG, TWOS_SEG, 0);

    // Mid-scan reset discards a pending load.
    for (int n = 0; n < 5; n++) step();
    pulse_load(16'h5555);
    step();
    step();
    rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    step();
    step();
    check_reset_outputs("mid_rst_held");
    rst_n = 1'b1;
    step();
    check_frame("rst_frame0", ZERO_LZ, ZERO_NZ, 0);
    step();
    check_frame("rst_frame1", ZERO_LZ, ZERO_NZ, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan.md
SEVEN_SEGMENT_SCAN -- requirements
Module: seven_segment_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed hex digits (1..8).
REQ-002 Parameter SCAN_DIV, default 25000: clock cycles per digit slot (>= 2).
REQ-003 Parameter GHOST_CYC, default 250: cycles at the start of each slot with all digits disabled (1 <= GHOST_CYC < SCAN_DIV).
REQ-004 Parameter SEG_ACTIVE_LOW, default 1: 1 means a lit segment drives 0.
REQ-005 Parameter DIG_ACTIVE_LOW, default 0: 1 means an enabled digit drives 0.
REQ-006 Parameter LZ_BLANK, default 1: 1 enables leading-zero suppression.
REQ-007 Ports: i_clk, one clock; i_rst_n, reset, asynchronous, active-low.
REQ-008 i_clk  in  1  system clock.
REQ-009 i_rst_n  in  1  asynchronous active-low reset.
REQ-010 i_value  in  4*NUM_DIGITS  hex value; nibble k drives digit k; digit 0 is least significant.
REQ-011 i_load  in  1  one-cycle strobe that requests capture of i_value.
REQ-012 o_seg  out  7  segment drive, bit0=A .. bit6=G, registered.
REQ-013 o_dig_en  out  NUM_DIGITS  one-hot digit enable, registered.
REQ-014 o_frame  out  1  one-cycle pulse on the first cycle of digit 0's slot.

Function
REQ-015 The slot counter SHALL count 0..SCAN_DIV-1 and wrap; at the wrap the digit index SHALL advance, and index NUM_DIGITS-1 SHALL wrap to 0.
REQ-016 The i_load strobe SHALL capture i_value into a pending register; the display register SHALL take the pending value only when the digit index wraps to 0, so that no frame shows mixed values.
REQ-017 An i_load arriving in the same cycle as a frame boundary SHALL be displayed from the next frame; the latest i_load before a boundary wins.
REQ-018 Glyphs (active-high GFEDCBA) SHALL be: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=67 A=77 b=7C C=39 d=5E E=79 F=71.
REQ-019 The block SHALL invert o_seg when SEG_ACTIVE_LOW=1.
REQ-020 The block SHALL invert o_dig_en when DIG_ACTIVE_LOW=1.
REQ-021 With LZ_BLANK=1, digit k>0 SHALL be blank (all segments off) when it and all more significant digits are zero; digit 0 SHALL never be blanked.
REQ-022 During slot cycles 0..GHOST_CYC-1, o_dig_en SHALL be all-inactive and o_seg SHALL be all-off; during cycles GHOST_CYC..SCAN_DIV-1, only the indexed digit SHALL be enabled, with its glyph on o_seg.
REQ-023 Outputs SHALL lag the counter state by exactly one register stage, and o_frame SHALL be aligned with the first o_seg/o_dig_en cycle of the digit 0 slot.

Reset
REQ-024 Asserting i_rst_n low SHALL immediately, without a clock, clear the slot counter, digit index, pending register and display register to 0.
REQ-025 During reset, o_seg SHALL be all-off, o_dig_en all-inactive and o_frame 0.
REQ-026 After release, the first clock SHALL begin digit 0's slot at cycle 0 (ghost interval).
REQ-027 A reset asserted mid-scan SHALL discard any pending load.

Structure
REQ-028 A shared package seven_seg_pkg SHALL hold the 16-entry active-high glyph table, the SEG_OFF constant and the segment-bit index constants.
REQ-029 A combinational sub-module hex_to_7seg (nibble plus blank in, active-high 7 bits out) SHALL be instantiated once, on the muxed digit.

Verification (NUM_DIGITS=4, SCAN_DIV=4, GHOST_CYC=1, active-low segments, active-high digits)
REQ-030 Reset: hold i_rst_n=0 mid-scan -> o_seg=7F and o_dig_en=0 asynchronously; after release, o_frame pulses at the first output cycle.
REQ-031 Load 0x1234, then wait one frame boundary -> slots show dig_en=0001/seg=19, 0010/30, 0100/24, 1000/79, each preceded by 1 ghost cycle of dig_en=0000/seg=7F.
REQ-032 Load 0x0050 -> digit0 seg=40, digit1 seg=12, digits 2 and 3 seg=7F; with LZ_BLANK=0, digits 2 and 3 seg=40.
REQ-033 Load 0xABCD mid-frame -> the current frame keeps its old value; the next frame shows 21, 03, 46, 08 on digits 0..3.
REQ-034 i_load pulses of 0x1111 then 0x2222 in the same frame, the second coinciding with the boundary cycle -> the next frame shows 0x1111 and the following frame shows 0x2222.
